sram_port_arbiter: RTL

- Shares the single synchronous SRAM port between the instruction-fetch requester (I) and the load/store requester (D) of the LoongArch core.
- Sits between the fetch/memory stages and the SRAM bus (en / we[3:0] / addr / wdata / rdata).
- Handshake is req/addr_ok/data_ok with SRAM read latency 1.
- Produces byte enables and lane-replicated write data, and flags misaligned accesses without touching SRAM.

---
 rtl/sram_port_arbiter_if.sv | 43 ++++
 rtl/sram_port_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter_if.sv
// Fetch port, data port and SRAM bus of sram_port_arbiter, grouped as one interface.
// Handshake: a requester holds xx_req and its command stable until xx_addr_ok is high in the same
// cycle; xx_data_ok (plus d_err for the data side) follows exactly one cycle after that acceptance.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, sram_rdata,
    output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata, d_err,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  // Requesters plus the SRAM itself.
  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, sram_rdata,
    input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata, d_err,
           sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port (read latency 1) between fetch (I) and load/store (D).
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed D priority.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  sram_port_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2,
    D_ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        grant_i, grant_d;
  logic        d_illegal;
  logic [3:0]  st_we;
  logic [DATA_W-1:0] st_wdata;
  logic        unused_ok;

  assign unused_ok   = ^bus.i_addr[1:0];
  assign dbg_state_o = state_q;

  assign d_illegal = (bus.d_size == 2'd3)
                  || ((bus.d_size == 2'd1) && bus.d_addr[0])
                  || ((bus.d_size == 2'd2) && (bus.d_addr[1:0] != 2'b00));

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (bus.i_req && bus.d_req) begin
        grant_d = !last_d_q;
        grant_i = last_d_q;
      end else begin
        grant_d = bus.d_req;
        grant_i = bus.i_req;
      end
    end
  end

  always_comb begin
    last_d_d = last_d_q;
    if (grant_d) begin
      last_d_d = 1'b1;
    end else if (grant_i) begin
      last_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  always_comb begin
    grant_d = !rst && bus.d_req;
    grant_i = !rst && bus.i_req && !bus.d_req;
  end
`endif

  // Store lanes: narrow data is replicated so the byte enables alone pick the target bytes.
  always_comb begin
    st_we    = 4'b0000;
    st_wdata = {DATA_W{1'b0}};
    case (bus.d_size)
      2'd0: begin
        st_we    = 4'b0001 << bus.d_addr[1:0];
        st_wdata = {4{bus.d_wdata[7:0]}};
      end
      2'd1: begin
        st_we    = 4'b0011 << bus.d_addr[1:0];
        st_wdata = {2{bus.d_wdata[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = bus.d_wdata;
      end
    endcase
  end

  always_comb begin
    state_d        = IDLE;
    bus.i_addr_ok  = grant_i;
    bus.d_addr_ok  = grant_d;
    bus.sram_en    = 1'b0;
    bus.sram_we    = 4'b0000;
    bus.sram_addr  = {ADDR_W{1'b0}};
    bus.sram_wdata = {DATA_W{1'b0}};
    bus.i_data_ok  = 1'b0;
    bus.i_rdata    = {DATA_W{1'b0}};
    bus.d_data_ok  = 1'b0;
    bus.d_rdata    = {DATA_W{1'b0}};
    bus.d_err      = 1'b0;

    if (grant_i) begin
      state_d       = I_WAIT;
      bus.sram_en   = 1'b1;
      bus.sram_addr = {bus.i_addr[ADDR_W-1:2], 2'b00};
    end else if (grant_d) begin
      if (d_illegal) begin
        // Accepted so the requester sees its error, but the SRAM is left untouched.
        state_d = D_ERR;
      end else begin
        state_d       = D_WAIT;
        bus.sram_en   = 1'b1;
        bus.sram_addr = {bus.d_addr[ADDR_W-1:2], 2'b00};
        if (bus.d_we) begin
          bus.sram_we    = st_we;
          bus.sram_wdata = st_wdata;
        end
      end
    end

    case (state_q)
      I_WAIT: begin
        bus.i_data_ok = 1'b1;
        bus.i_rdata   = bus.sram_rdata;
      end
      D_WAIT: begin
        bus.d_data_ok = 1'b1;
        bus.d_rdata   = bus.sram_rdata;
      end
      D_ERR: begin
        bus.d_data_ok = 1'b1;
        bus.d_err     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
